// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks in-flight requests,
// buffers returned words in a FIFO and handles branch/jal/jalr redirects with flush.
module fetch_unit #(
  parameter int unsigned         XLEN         = 32,
  parameter int unsigned         DEPTH        = 4,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            fetch_hold,
  input  logic [2:0]      redirect_mode,
  input  logic            redirect_taken,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_imm,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_inc,
  output logic            misalign_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    RD_NONE   = 3'd0,
    RD_BRANCH = 3'd1,
    RD_JAL    = 3'd2,
    RD_JALR   = 3'd3
  } redirect_e;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] jalr_sum;

  logic [31:0]     buf_data [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard_cnt;
  logic [CW:0]     occupancy;

  logic fire;
  logic accept;
  logic pop;
  logic push;
  logic [CW-1:0] rsp_inc;

  assign pc_sum   = redirect_pc + redirect_imm;
  assign jalr_sum = redirect_base + redirect_imm;

  always_comb begin
    fire   = 1'b0;
    target = pc_sum;
    case (redirect_mode)
      RD_BRANCH: fire = redirect_taken;
      RD_JAL:    fire = 1'b1;
      RD_JALR: begin
        fire   = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default:   fire = 1'b0;
    endcase
  end

  // Request slots are reserved against buffer space so the FIFO can never overflow.
  assign occupancy      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !fetch_hold && !misalign_err && !fire &&
                          (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign inst_valid  = !reset && (count != '0);
  assign pop         = inst_valid && inst_ready;
  assign push        = imem_rsp_valid && !fire && (discard_cnt == '0);
  assign rsp_inc     = CW'(imem_rsp_valid);

  assign inst_data   = buf_data[head];
  assign inst_pc     = buf_pc[head];
  assign inst_pc_inc = inst_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= imem_rsp_data;
      buf_pc[tail]   <= rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_VECTOR;
      rsp_pc       <= RESET_VECTOR;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      outstanding  <= '0;
      discard_cnt  <= '0;
      misalign_err <= 1'b0;
    end else if (fire) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      fetch_pc    <= target;
      rsp_pc      <= target;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= outstanding - rsp_inc;
      discard_cnt <= outstanding - rsp_inc;
      if (target[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (push) begin
        tail   <= tail + AW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - rsp_inc;
      if (imem_rsp_valid && (discard_cnt != '0)) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run checked
// against a queue-based model of requests in flight and the instruction buffer.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_hold;
  logic [2:0]  redirect_mode;
  logic        redirect_taken;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_inc;
  logic        misalign_err;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .fetch_hold(fetch_hold), .redirect_mode(redirect_mode), .redirect_taken(redirect_taken),
    .redirect_pc(redirect_pc), .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc_inc(inst_pc_inc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [31:0] pc; bit drop; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } be_t;
  fl_t         infl[$];
  be_t         bufq[$];
  logic [31:0] m_pc;
  bit          m_mis;
  bit          e_req;
  bit          e_fire;
  logic [31:0] e_tgt;
  bit          rsp_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_clear();
    infl.delete();
    bufq.delete();
    m_pc  = 32'h0;
    m_mis = 1'b0;
  endtask

  // Called at the falling edge once the scenario has set its inputs.
  task automatic prep();
    imem_rsp_valid = rsp_en && (infl.size() > 0);
    if (imem_rsp_valid) imem_rsp_data = mem_word(infl[0].pc);
    else                imem_rsp_data = $urandom;
    e_fire = (redirect_mode == 3'd2) || (redirect_mode == 3'd3) ||
             (redirect_mode == 3'd1 && redirect_taken);
    if (redirect_mode == 3'd3) e_tgt = (redirect_base + redirect_imm) & 32'hFFFF_FFFE;
    else                       e_tgt = redirect_pc + redirect_imm;
    e_req = !fetch_hold && !m_mis && !e_fire && ((bufq.size() + infl.size()) < DEPTH);
    #1;
  endtask

  task automatic advance();
    bit  acc, pop, rsp;
    fl_t f;
    acc = e_req && imem_req_ready;
    pop = (bufq.size() > 0) && inst_ready;
    rsp = imem_rsp_valid;
    @(posedge clk);
    if (pop) void'(bufq.pop_front());
    if (rsp) begin
      f = infl.pop_front();
      if (!f.drop && !e_fire) bufq.push_back('{f.pc, mem_word(f.pc)});
    end
    if (e_fire) begin
      bufq.delete();
      foreach (infl[i]) infl[i].drop = 1'b1;
      m_pc = e_tgt;
      if (e_tgt[1:0] != 2'b00) m_mis = 1'b1;
    end
    if (acc) begin
      infl.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
    redirect_mode  = 3'd0;
    redirect_taken = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_hold = 1'b0; redirect_mode = 3'd0; redirect_taken = 1'b0;
    redirect_pc = '0; redirect_base = '0; redirect_imm = '0;
    inst_ready = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_hold = 1'b0; redirect_mode = 3'd0; redirect_taken = 1'b0;
    redirect_pc = '0; redirect_base = '0; redirect_imm = '0;
    inst_ready = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    rsp_en = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_valid=%b inst_valid=%b misalign=%b, want 0 0 0",
               imem_req_valid, inst_valid, misalign_err);
    end
    reset = 1'b0;
    model_clear();
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b addr=%h, want 1 00000000", imem_req_valid, imem_req_addr);
    end
    advance();
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      prep();
      n_tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL stream_req cyc %0d: valid=%b addr=%h, want 1 %h", i, imem_req_valid, imem_req_addr, 32'(4 * i));
      end
      if (i >= 2) begin
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (i - 2)) || inst_pc_inc !== 32'(4 * (i - 1)) ||
            inst_data !== mem_word(32'(4 * (i - 2)))) begin
          n_fail++;
          $display("FAIL stream_inst cyc %0d: valid=%b pc=%h inc=%h data=%h, want 1 %h %h %h", i,
                   inst_valid, inst_pc, inst_pc_inc, inst_data, 32'(4 * (i - 2)), 32'(4 * (i - 1)),
                   mem_word(32'(4 * (i - 2))));
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prep();
      if (imem_req_valid && imem_req_ready) acc++;
      advance();
    end
    n_tests++;
    if (acc != DEPTH) begin
      n_fail++;
      $display("FAIL bp_accept_count: got %0d, want %0d", acc, DEPTH);
    end
    inst_ready = 1'b1;
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_full: req_valid=%b inst_valid=%b pc=%h, want 0 1 00000000", imem_req_valid, inst_valid, inst_pc);
    end
    advance();
    inst_ready = 1'b0;
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_refill: valid=%b addr=%h, want 1 00000010", imem_req_valid, imem_req_addr);
    end
    advance();
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_refull: valid=%b, want 0", imem_req_valid);
    end
    advance();
  endtask

  task automatic test_jal_discard();
    bit seen_req = 0, seen_iv = 0;
    do_reset();
    inst_ready = 1'b1;
    rsp_en = 1'b0;
    repeat (3) begin prep(); advance(); end
    rsp_en = 1'b1;
    redirect_mode = 3'd2; redirect_pc = 32'h100; redirect_imm = 32'h40;
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_redirect_cycle_req: valid=%b, want 0", imem_req_valid);
    end
    advance();
    for (int i = 0; i < 8; i++) begin
      prep();
      if (!seen_req && imem_req_valid) begin
        seen_req = 1;
        n_tests++;
        if (imem_req_addr !== 32'h140) begin
          n_fail++;
          $display("FAIL jal_first_addr: got %h, want 00000140", imem_req_addr);
        end
      end
      if (!seen_iv && inst_valid) begin
        seen_iv = 1;
        n_tests++;
        if (inst_pc !== 32'h140) begin
          n_fail++;
          $display("FAIL jal_first_inst: pc=%h, want 00000140", inst_pc);
        end
      end
      advance();
    end
    n_tests++;
    if (!seen_req || !seen_iv) begin
      n_fail++;
      $display("FAIL jal_progress: req_seen=%0d inst_seen=%0d, want 1 1", seen_req, seen_iv);
    end
  endtask

  task automatic test_latency();
    do_reset();
    fetch_hold = 1'b1;
    inst_ready = 1'b1;
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_req: valid=%b, want 0", imem_req_valid);
    end
    advance();
    fetch_hold = 1'b0;
    redirect_mode = 3'd2; redirect_pc = 32'h300; redirect_imm = 32'h20;
    prep(); advance();
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h320 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_r1: valid=%b addr=%h inst_valid=%b, want 1 00000320 0", imem_req_valid, imem_req_addr, inst_valid);
    end
    advance();
    prep();
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_r2: inst_valid=%b, want 0", inst_valid);
    end
    advance();
    prep();
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h320 || inst_data !== mem_word(32'h320)) begin
      n_fail++;
      $display("FAIL lat_r3: valid=%b pc=%h data=%h, want 1 00000320 %h", inst_valid, inst_pc, inst_data, mem_word(32'h320));
    end
    advance();
  endtask

  task automatic test_jalr_branch();
    logic [31:0] a0;
    do_reset();
    inst_ready = 1'b1;
    repeat (4) begin prep(); advance(); end
    redirect_mode = 3'd3; redirect_base = 32'h203; redirect_imm = 32'h1;
    prep(); advance();
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h204) begin
      n_fail++;
      $display("FAIL jalr_target: valid=%b addr=%h, want 1 00000204", imem_req_valid, imem_req_addr);
    end
    advance();
    repeat (3) begin prep(); advance(); end
    for (int m = 0; m < 2; m++) begin
      redirect_mode = (m == 0) ? 3'd1 : 3'd6;
      redirect_taken = (m == 0) ? 1'b0 : 1'b1;
      redirect_pc = 32'h8000; redirect_imm = 32'h100; redirect_base = 32'h4000;
      prep();
      a0 = imem_req_addr;
      n_tests++;
      if (imem_req_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL noredirect_req mode %0d: valid=%b, want 1", redirect_mode, imem_req_valid);
      end
      advance();
      prep();
      n_tests++;
      if (imem_req_addr !== a0 + 32'd4 || misalign_err !== 1'b0) begin
        n_fail++;
        $display("FAIL noredirect_next %0d: addr=%h misalign=%b, want %h 0", m, imem_req_addr, misalign_err, a0 + 32'd4);
      end
      advance();
    end
  endtask

  task automatic test_misalign();
    do_reset();
    inst_ready = 1'b1;
    repeat (3) begin prep(); advance(); end
    redirect_mode = 3'd2; redirect_pc = 32'h100; redirect_imm = 32'h2;
    prep(); advance();
    for (int i = 0; i < 6; i++) begin
      prep();
      n_tests++;
      if (misalign_err !== 1'b1 || imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_sticky cyc %0d: err=%b req_valid=%b, want 1 0", i, misalign_err, imem_req_valid);
      end
      advance();
    end
    do_reset();
    inst_ready = 1'b1;
    prep();
    n_tests++;
    if (misalign_err !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_cleared: err=%b valid=%b addr=%h, want 0 1 00000000", misalign_err, imem_req_valid, imem_req_addr);
    end
    advance();
  endtask

  task automatic test_wrap();
    do_reset();
    inst_ready = 1'b1;
    redirect_mode = 3'd2; redirect_pc = 32'hFFFF_FFF0; redirect_imm = 32'hC;
    prep(); advance();
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_top: valid=%b addr=%h, want 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    advance();
    prep();
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: valid=%b addr=%h, want 1 00000000", imem_req_valid, imem_req_addr);
    end
    advance();
    prep();
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_pc_inc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_inc: valid=%b pc=%h inc=%h, want 1 fffffffc 00000000", inst_valid, inst_pc, inst_pc_inc);
    end
    advance();
  endtask

  task automatic test_random();
    bit exp_iv;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (m_mis && $urandom_range(0, 15) == 0) do_reset();
      inst_ready     = ($urandom_range(0, 9) < 7);
      fetch_hold     = ($urandom_range(0, 9) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      rsp_en         = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) begin
        redirect_mode  = 3'($urandom_range(1, 7));
        redirect_taken = $urandom_range(0, 1) == 1;
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
        redirect_base  = $urandom & 32'hFFFF_FFFC;
        redirect_imm   = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 63)) << 2
                                                    : -(32'($urandom_range(1, 63)) << 2);
        if ($urandom_range(0, 9) == 0) redirect_imm = redirect_imm | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) redirect_base = redirect_base | 32'($urandom_range(1, 3));
      end
      prep();
      exp_iv = bufq.size() > 0;
      n_tests++;
      if (imem_req_valid !== e_req) begin
        n_fail++;
        $display("FAIL rnd_req_valid cyc %0d: got %b want %b", c, imem_req_valid, e_req);
      end
      n_tests++;
      if (imem_req_addr !== m_pc) begin
        n_fail++;
        $display("FAIL rnd_req_addr cyc %0d: got %h want %h", c, imem_req_addr, m_pc);
      end
      n_tests++;
      if (inst_valid !== exp_iv || misalign_err !== m_mis) begin
        n_fail++;
        $display("FAIL rnd_flags cyc %0d: inst_valid=%b misalign=%b want %b %b", c, inst_valid, misalign_err, exp_iv, m_mis);
      end
      if (exp_iv) begin
        n_tests++;
        if (inst_pc !== bufq[0].pc || inst_data !== bufq[0].data || inst_pc_inc !== bufq[0].pc + 32'd4) begin
          n_fail++;
          $display("FAIL rnd_head cyc %0d: pc=%h data=%h inc=%h want %h %h %h", c, inst_pc, inst_data,
                   inst_pc_inc, bufq[0].pc, bufq[0].data, bufq[0].pc + 32'd4);
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jal_discard();
    test_latency();
    test_jalr_branch();
    test_misalign();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width; SHALL be >= 32.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries and max in-flight requests; SHALL be a power of two >= 2.
REQ-003 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address; SHALL be word-aligned.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_addr  out  XLEN  fetch address.
REQ-008 imem_req_ready  in  1  memory accepts request when high with imem_req_valid.
REQ-009 imem_rsp_valid  in  1  instruction word returned; in request order, never earlier than cycle after acceptance.
REQ-010 imem_rsp_data  in  32  returned instruction word.
REQ-011 fetch_hold  in  1  suppresses new requests; buffer and responses unaffected.
REQ-012 redirect_mode  in  3  0 none, 1 branch, 2 jal, 3 jalr, 4-7 treated as 0.
REQ-013 redirect_taken  in  1  branch outcome; used only in mode 1.
REQ-014 redirect_pc  in  XLEN  PC of redirecting instruction.
REQ-015 redirect_base  in  XLEN  rs1 value for jalr.
REQ-016 redirect_imm  in  XLEN  sign-extended offset.
REQ-017 inst_valid  out  1  buffer head valid.
REQ-018 inst_ready  in  1  consumer accepts head when high with inst_valid.
REQ-019 inst_data  out  32  head instruction word.
REQ-020 inst_pc  out  XLEN  head instruction address.
REQ-021 inst_pc_inc  out  XLEN  inst_pc + 4, modulo 2^XLEN.
REQ-022 misalign_err  out  1  sticky: redirect target not word-aligned.

Function
REQ-023 Target: mode 1/2 redirect_pc+redirect_imm; mode 3 (redirect_base+redirect_imm) with bit 0 cleared; all sums modulo 2^XLEN.
REQ-024 Redirect fires when mode 2 or 3, or mode 1 with redirect_taken=1; mode 1 not-taken has no effect.
REQ-025 imem_req_valid SHALL be high iff not reset, not fetch_hold, not misalign_err, no redirect this cycle, and buffer_count+outstanding < DEPTH.
REQ-026 imem_req_addr SHALL equal fetch_pc; fetch_pc +4 (wrapping) on each accepted request.
REQ-027 outstanding SHALL +1 on acceptance, -1 on response, net 0 when both in one cycle.
REQ-028 Non-discarded response written to buffer tail with its PC; inst_valid for it rises the following cycle (no bypass).
REQ-029 Buffer is FIFO; head popped on inst_valid & inst_ready; simultaneous push and pop allowed at any occupancy, including full.
REQ-030 On firing redirect: fetch_pc <= target; buffer emptied next cycle; discard_cnt <= outstanding count after this cycle's response; no request issued this cycle.
REQ-031 Handshake coinciding with a redirect consumes that head; all other entries are discarded.
REQ-032 Response arriving in redirect cycle is dropped; while discard_cnt>0 each response decrements it and is not buffered.
REQ-033 Minimum redirect-to-instruction latency: redirect cycle R, request R+1, response R+2, inst_valid R+3.
REQ-034 Target with bits [1:0] != 0 sets misalign_err, flushes as REQ-030, then issues no requests until reset.
REQ-035 Buffer overflow SHALL be impossible by construction of REQ-025.

Reset
REQ-036 While reset high: imem_req_valid=0, inst_valid=0, misalign_err=0; fetch_pc=RESET_VECTOR, buffer empty, outstanding=0, discard_cnt=0.
REQ-037 Reset mid-operation aborts all; responses after reset deasserts for pre-reset requests are outside contract (memory reset together).
REQ-038 First cycle after reset deasserts: imem_req_valid=1, imem_req_addr=RESET_VECTOR (if imem ready path permits).

Verification
REQ-039 Reset release, ready=1, 1-cycle memory, inst_ready=1 -> addresses 0x0,0x4,0x8... one per cycle; inst_pc sequence matches, inst_pc_inc = inst_pc+4.
REQ-040 inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; one pop -> one new request next cycle.
REQ-041 3 outstanding, jal redirect_pc=0x100 imm=0x40 -> 3 responses dropped, next request addr 0x140, inst_valid at R+3 with inst_pc 0x140.
REQ-042 jalr base=0x203 imm=0x1 -> target 0x204; branch mode taken=0 -> stream unchanged.
REQ-043 jal imm=0x2 from 0x100 -> misalign_err=1 sticky, no further requests until reset pulse.
REQ-044 fetch_pc=0xFFFF_FFFC (XLEN=32) -> next request 0x0, inst_pc_inc of that word = 0x0.
